fpdiv_seq: RTL and testbench
============================

Name: fpdiv_seq

Overview:
Iterative IEEE-754 half-precision divider computing DIV_o = opA_i / opB_i. It is the inverse of the team's combinational fp16 multiplier and lives beside it in the fp16 arithmetic set. It uses restoring mantissa division, one quotient bit per clock, and has valid/ready handshakes on both the operand and result sides.

Parameters:
EXP_W, 5, exponent width (only the default is verified)
FRAC_W, 10, stored fraction width (only the default is verified)
BIAS, 15, exponent bias

Ports:
clk_i  input  1  clock; all state updates on the rising edge
rst_i  input  1  reset, synchronous, active-high
valid_i  input  1  operands present
ready_o  output  1  divider can accept; high only in IDLE
opA_i  input  16  dividend (fp16)
opB_i  input  16  divisor (fp16)
valid_o  output  1  result present; held until accepted
ready_i  input  1  consumer accepts the result
DIV_o  output  16  quotient (fp16)
dbz_o  output  1  divide-by-zero flag (finite nonzero / zero); qualified by valid_o

Behaviour:
- One clock, clk_i. rst_i is synchronous and active-high.
- Reset values: state=IDLE, valid_o=0, DIV_o=16'h0000, dbz_o=0, ready_o=1.
- Reset at any time, including mid-DIV or in DONE: return to IDLE next edge and drop the operation.
- FSM states and transitions:
  - IDLE: valid_i&&ready_o captures operands; go to DIV, iter=0.
  - DIV: 12 cycles (iter 0..11), one quotient bit per cycle; after iter 11 go to NORM.
  - NORM: register DIV_o and dbz_o; go to DONE.
  - DONE: valid_o=1, outputs stable; valid_o&&ready_i returns to IDLE.
- Latency: valid_o rises 14 edges after the accept edge. Latency is fixed, including for special operands, which still traverse DIV.
- Throughput: one operation every 15 cycles minimum (accept edge + 12 DIV + NORM + one DONE cycle).
- No accept outside IDLE. valid_i in other states is ignored and does not queue.
- ready_o is combinational from state (state==IDLE).
- Operand classes, per operand (e = exp field, f = fraction field):
  - e==0: zero (subnormals flushed to zero)
  - e==31, f==0: inf
  - e==31, f!=0: NaN
  - otherwise: normal, mantissa m={1,f} (11 bits)
- Sign: sA^sB, applied to zero/inf results. NaN result is always 16'h7E00.
- Special results, in priority order:
  - either NaN, 0/0, or inf/inf -> 16'h7E00, dbz_o=0
  - inf/x -> signed inf
  - x/inf -> signed zero
  - 0/x -> signed zero
  - finite nonzero / 0 -> signed inf (sign|16'h7C00), dbz_o=1
- Normal path, restoring division:
  - r starts at 12-bit zero-extended mA.
  - Each DIV cycle: q_bit = (r>=mB); if q_bit, r=r-mB; then r=r<<1; q={q[10:0],q_bit}.
  - After 12 bits, q is in [0x400,0xFFF].
- Exponent: 7-bit signed e = eA - eB + BIAS - (q[11]?0:1).
  - Fraction = q[11] ? q[10:1] : q[9:0].
  - Rounding is truncation (toward zero), matching the multiplier.
- Range clamps:
  - e<=0: signed zero (flush, no subnormal output)
  - e>=31: signed inf
  - otherwise: {sign, e[4:0], fraction}
- DIV_o/dbz_o change only at the NORM edge and hold through DONE and IDLE until the next NORM.

Decomposition:
- Package fp16_pkg, shared with the multiplier:
  - EXP_W, FRAC_W, BIAS
  - constants QNAN=16'h7E00, POS_INF=16'h7C00
  - enum fp16_class_e {FP_ZERO, FP_NORM, FP_INF, FP_NAN}
  - enum fpdiv_state_e {IDLE, DIV, NORM, DONE}
- Sub-module fp16_classify: combinational, fp16 in -> class, sign, exp, 11-bit mantissa out. Instantiated twice.

Test Plan:
- 0x3C00/0x4000 (1/2) -> DIV_o=0x3800, dbz_o=0; valid_o high exactly 14 edges after accept; ready_o=0 throughout.
- 0x4200/0x4000 (3/2) -> 0x3E00; 0x3C00/0x4200 (1/3) -> 0x3555 (truncated).
- 0xC000/0x0000 -> 0xFC00, dbz_o=1; 0x0000/0x0000 -> 0x7E00, dbz_o=0; 0x7C00/0x7C00 -> 0x7E00; 0x4000/0xFC00 -> 0x8000.
- Clamps: 0x7BFF/0x0400 -> 0x7C00 (overflow); 0x0400/0x7BFF -> 0x0000 (underflow); subnormal 0x0001/0x3C00 -> 0x0000.
- Back-pressure: hold ready_i=0 for 5 cycles in DONE -> DIV_o and valid_o stable; valid_i pulsed with new operands is ignored; ready_i=1 -> IDLE next edge, ready_o=1.
- rst_i pulsed at DIV iter 5 -> next cycle valid_o=0, ready_o=1, DIV_o=0x0000; a fresh 0x3C00/0x4000 then yields 0x3800.

Source files
------------

// File: rtl/fp16_pkg.sv
// Shared fp16 arithmetic definitions: field widths, special encodings,
// operand classes and the divider's state encoding.
package fp16_pkg;

  localparam int EXP_W  = 5;
  localparam int FRAC_W = 10;
  localparam int BIAS   = 15;

  localparam logic [15:0] QNAN    = 16'h7E00;
  localparam logic [15:0] POS_INF = 16'h7C00;

  typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fp16_class_e;

  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} fpdiv_state_e;

endpackage

// File: rtl/fp16_classify.sv
// Combinational fp16 operand decoder: class, sign, exponent field and the
// 11-bit significand with hidden one (zero for non-normal operands).
module fp16_classify
  import fp16_pkg::*;
#(
  parameter int EW = EXP_W,
  parameter int FW = FRAC_W
) (
  input  logic [EW+FW:0] val,
  output fp16_class_e    cls,
  output logic           sign,
  output logic [EW-1:0]  expo,
  output logic [FW:0]    mant
);

  logic [FW-1:0] frac;

  assign sign = val[EW+FW];
  assign expo = val[EW+FW-1:FW];
  assign frac = val[FW-1:0];

  // Subnormals are flushed to zero, so an all-zero exponent is always FP_ZERO.
  always_comb begin
    cls  = FP_NORM;
    mant = '0;
    if (expo == '0) begin
      cls = FP_ZERO;
    end else if (expo == '1) begin
      cls = (frac == '0) ? FP_INF : FP_NAN;
    end else begin
      mant = {1'b1, frac};
    end
  end

endmodule

// File: rtl/fpdiv_seq.sv
// Iterative fp16 divider: restoring mantissa division producing one quotient
// bit per clock, with valid/ready handshakes on operands and result.
module fpdiv_seq #(
  parameter int EXP_W  = fp16_pkg::EXP_W,
  parameter int FRAC_W = fp16_pkg::FRAC_W,
  parameter int BIAS   = fp16_pkg::BIAS
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [EXP_W+FRAC_W:0] opA_i,
  input  logic [EXP_W+FRAC_W:0] opB_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [EXP_W+FRAC_W:0] DIV_o,
  output logic                  dbz_o
);

  import fp16_pkg::*;

  localparam int W     = EXP_W + FRAC_W + 1;
  localparam int MW    = FRAC_W + 1;
  localparam int QW    = FRAC_W + 2;
  localparam int SEW   = EXP_W + 2;
  localparam int ITERS = QW;
  localparam int IW    = $clog2(ITERS);

  localparam logic signed [SEW-1:0] EXP_ZERO = '0;
  localparam logic signed [SEW-1:0] EXP_MAX  = SEW'((1 << EXP_W) - 1);

  fpdiv_state_e state, next_state;

  fp16_class_e      in_cls_a, in_cls_b, cls_a, cls_b;
  logic             in_sign_a, in_sign_b, res_sign;
  logic [EXP_W-1:0] in_exp_a, in_exp_b, exp_a, exp_b;
  logic [MW-1:0]    in_mant_a, in_mant_b, mant_b;
  logic [IW-1:0]    iter;
  logic [QW-1:0]    rem, quo, rem_sub, rem_next;
  logic             q_bit, accept;

  logic signed [SEW-1:0] exp_res;
  logic [FRAC_W-1:0]     frac_res;
  logic [W-1:0]          signed_inf, signed_zero, div_res;
  logic                  div_dbz;

  fp16_classify #(.EW(EXP_W), .FW(FRAC_W)) u_class_a (
    .val(opA_i), .cls(in_cls_a), .sign(in_sign_a), .expo(in_exp_a), .mant(in_mant_a)
  );

  fp16_classify #(.EW(EXP_W), .FW(FRAC_W)) u_class_b (
    .val(opB_i), .cls(in_cls_b), .sign(in_sign_b), .expo(in_exp_b), .mant(in_mant_b)
  );

  assign accept = valid_i && ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (valid_i) next_state = DIV;
      DIV:  if (iter == IW'(ITERS - 1)) next_state = NORM;
      NORM: next_state = DONE;
      DONE: if (ready_i) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ready_o = (state == IDLE);
    valid_o = (state == DONE);
  end

  // One restoring step; the remainder stays below 2*mant_b so QW bits suffice.
  always_comb begin
    q_bit    = (rem >= {1'b0, mant_b});
    rem_sub  = q_bit ? (rem - {1'b0, mant_b}) : rem;
    rem_next = {rem_sub[QW-2:0], 1'b0};
  end

  always_comb begin
    exp_res     = SEW'(exp_a) - SEW'(exp_b) + SEW'(BIAS) - SEW'(!quo[QW-1]);
    frac_res    = quo[QW-1] ? quo[FRAC_W:1] : quo[FRAC_W-1:0];
    signed_zero = {res_sign, {(W-1){1'b0}}};
    signed_inf  = POS_INF | signed_zero;
    div_dbz     = 1'b0;
    div_res     = signed_zero;
    if (cls_a == FP_NAN || cls_b == FP_NAN ||
        (cls_a == FP_ZERO && cls_b == FP_ZERO) ||
        (cls_a == FP_INF && cls_b == FP_INF)) begin
      div_res = QNAN;
    end else if (cls_a == FP_INF) begin
      div_res = signed_inf;
    end else if (cls_b == FP_INF || cls_a == FP_ZERO) begin
      div_res = signed_zero;
    end else if (cls_b == FP_ZERO) begin
      div_res = signed_inf;
      div_dbz = 1'b1;
    end else if (exp_res <= EXP_ZERO) begin
      div_res = signed_zero;
    end else if (exp_res >= EXP_MAX) begin
      div_res = signed_inf;
    end else begin
      div_res = {res_sign, exp_res[EXP_W-1:0], frac_res};
    end
  end

  // Special operands still run the full DIV sequence so latency never varies.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      iter     <= '0;
      rem      <= '0;
      quo      <= '0;
      mant_b   <= '0;
      exp_a    <= '0;
      exp_b    <= '0;
      cls_a    <= FP_ZERO;
      cls_b    <= FP_ZERO;
      res_sign <= 1'b0;
      DIV_o    <= '0;
      dbz_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          iter     <= '0;
          rem      <= {1'b0, in_mant_a};
          quo      <= '0;
          mant_b   <= in_mant_b;
          exp_a    <= in_exp_a;
          exp_b    <= in_exp_b;
          cls_a    <= in_cls_a;
          cls_b    <= in_cls_b;
          res_sign <= in_sign_a ^ in_sign_b;
        end
        DIV: begin
          rem  <= rem_next;
          quo  <= {quo[QW-2:0], q_bit};
          iter <= iter + IW'(1);
        end
        NORM: begin
          DIV_o <= div_res;
          dbz_o <= div_dbz;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpdiv_seq.sv
// Self-checking bench for fpdiv_seq: directed fp16 vectors with literal
// expectations plus random operands checked against an arithmetic model.
module tb_fpdiv_seq;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [15:0] opA_i = '0;
  logic [15:0] opB_i = '0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [15:0] DIV_o;
  logic        dbz_o;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_res_q[$];
  logic        exp_dbz_q[$];

  fpdiv_seq dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .opA_i(opA_i), .opB_i(opB_i), .valid_o(valid_o), .ready_i(ready_i),
    .DIV_o(DIV_o), .dbz_o(dbz_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_output(input string name, input logic [15:0] got, input logic [15:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, expv);
    end
  endtask

  // Reference quotient: exact integer division of the significands, then truncation.
  function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] r, output logic d);
    int ea, eb, fa, fb, q, e, frac, sgn;
    bit za, zb, ia, ib, na, nb;
    ea = int'(a[14:10]); eb = int'(b[14:10]);
    fa = int'(a[9:0]);   fb = int'(b[9:0]);
    sgn = (a[15] ^ b[15]) ? 32768 : 0;
    za = (ea == 0); zb = (eb == 0);
    ia = (ea == 31 && fa == 0); ib = (eb == 31 && fb == 0);
    na = (ea == 31 && fa != 0); nb = (eb == 31 && fb != 0);
    d = 1'b0;
    if (na || nb || (za && zb) || (ia && ib)) r = 16'h7E00;
    else if (ia) r = 16'(sgn + 31744);
    else if (ib || za) r = 16'(sgn);
    else if (zb) begin r = 16'(sgn + 31744); d = 1'b1; end
    else begin
      q = ((1024 + fa) * 2048) / (1024 + fb);
      e = ea - eb + 15 - ((q < 2048) ? 1 : 0);
      frac = (q >= 2048) ? ((q / 2) % 1024) : (q % 1024);
      if (e <= 0) r = 16'(sgn);
      else if (e >= 31) r = 16'(sgn + 31744);
      else r = 16'(sgn + e * 1024 + frac);
    end
  endfunction

  // Every cycle a result is presented it must match the oldest expectation.
  always @(negedge clk_i) begin
    if (!rst_i && valid_o === 1'b1) begin
      if (exp_res_q.size() == 0) begin
        check_output("unexpected_valid", {15'b0, valid_o}, 16'h0000);
      end else begin
        check_output("model_div", DIV_o, exp_res_q[0]);
        check_output("model_dbz", {15'b0, dbz_o}, {15'b0, exp_dbz_q[0]});
        if (ready_i) begin
          void'(exp_res_q.pop_front());
          void'(exp_dbz_q.pop_front());
        end
      end
    end
  end

  task automatic apply_reset();
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    exp_res_q.delete();
    exp_dbz_q.delete();
  endtask

  // Called at posedge+1 in IDLE; returns the result once valid_o is seen.
  task automatic apply_stimulus(input logic [15:0] a, input logic [15:0] b, input int hold,
                                input bit pulse_valid, output logic [15:0] res, output logic dbz);
    logic [15:0] mr;
    logic        md;
    int          lat;
    bit          rdy_high;
    model(a, b, mr, md);
    exp_res_q.push_back(mr);
    exp_dbz_q.push_back(md);
    check_output("ready_idle", {15'b0, ready_o}, 16'h0001);
    opA_i = a; opB_i = b; valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    lat = 0;
    rdy_high = 1'b0;
    while (valid_o !== 1'b1 && lat < 40) begin
      if (ready_o !== 1'b0) rdy_high = 1'b1;
      @(posedge clk_i); #1;
      lat++;
    end
    // DONE is entered on the 13th edge after accept; the consumer sees it on the 14th.
    check_output("latency", 16'(lat), 16'd13);
    check_output("ready_busy", {15'b0, rdy_high}, 16'h0000);
    res = DIV_o;
    dbz = dbz_o;
    for (int i = 0; i < hold; i++) begin
      if (pulse_valid && i == 1) begin
        valid_i = 1'b1; opA_i = 16'h4400; opB_i = 16'h3C00;
      end else begin
        valid_i = 1'b0;
      end
      @(posedge clk_i); #1;
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    ready_i = 1'b0;
    check_output("ready_after", {15'b0, ready_o}, 16'h0001);
    check_output("valid_after", {15'b0, valid_o}, 16'h0000);
  endtask

  function automatic logic [15:0] rand_op();
    logic [15:0] v;
    v = 16'($urandom);
    case ($urandom_range(0, 9))
      0: v[14:10] = 5'd0;
      1: v[14:10] = 5'd31;
      2: if (v[0]) v[14:0] = 15'h7C00; else v[14:0] = 15'h0000;
      3: v[14:10] = 5'($urandom_range(1, 3));
      4: v[14:10] = 5'($urandom_range(28, 30));
      default: v[14:10] = 5'($urandom_range(1, 30));
    endcase
    return v;
  endfunction

  typedef struct { logic [15:0] a; logic [15:0] b; logic [15:0] r; logic d; } vec_t;
  vec_t vecs[] = '{
    '{16'h3C00, 16'h4000, 16'h3800, 1'b0},
    '{16'h4200, 16'h4000, 16'h3E00, 1'b0},
    '{16'h3C00, 16'h4200, 16'h3555, 1'b0},
    '{16'hC000, 16'h0000, 16'hFC00, 1'b1},
    '{16'h0000, 16'h0000, 16'h7E00, 1'b0},
    '{16'h7C00, 16'h7C00, 16'h7E00, 1'b0},
    '{16'h4000, 16'hFC00, 16'h8000, 1'b0},
    '{16'h7BFF, 16'h0400, 16'h7C00, 1'b0},
    '{16'h0400, 16'h7BFF, 16'h0000, 1'b0},
    '{16'h0001, 16'h3C00, 16'h0000, 1'b0}
  };

  initial begin
    logic [15:0] res, mr;
    logic        dbz, md;

    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    check_output("reset_valid", {15'b0, valid_o}, 16'h0000);
    check_output("reset_ready", {15'b0, ready_o}, 16'h0001);
    check_output("reset_div", DIV_o, 16'h0000);
    check_output("reset_dbz", {15'b0, dbz_o}, 16'h0000);

    model(16'h3C00, 16'h4200, mr, md);
    check_output("model_pin_third", mr, 16'h3555);
    model(16'hC000, 16'h0000, mr, md);
    check_output("model_pin_dbz", {15'b0, md}, 16'h0001);

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].a, vecs[i].b, 0, 1'b0, res, dbz);
      check_output($sformatf("vec%0d_div", i), res, vecs[i].r);
      check_output($sformatf("vec%0d_dbz", i), {15'b0, dbz}, {15'b0, vecs[i].d});
    end

    apply_stimulus(16'h4200, 16'h4000, 5, 1'b1, res, dbz);
    check_output("bp_div", res, 16'h3E00);
    repeat (3) begin
      @(posedge clk_i); #1;
      check_output("bp_no_queue_ready", {15'b0, ready_o}, 16'h0001);
      check_output("bp_no_queue_valid", {15'b0, valid_o}, 16'h0000);
    end

    opA_i = 16'h4200; opB_i = 16'h4200; valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1;
    apply_reset();
    check_output("midrst_valid", {15'b0, valid_o}, 16'h0000);
    check_output("midrst_ready", {15'b0, ready_o}, 16'h0001);
    check_output("midrst_div", DIV_o, 16'h0000);
    apply_stimulus(16'h3C00, 16'h4000, 0, 1'b0, res, dbz);
    check_output("midrst_fresh", res, 16'h3800);

    for (int n = 0; n < 40; n++) begin
      apply_stimulus(rand_op(), rand_op(), int'($urandom_range(0, 3)), 1'b0, res, dbz);
    end

    check_output("queue_drained", 16'(exp_res_q.size()), 16'h0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
